// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding read to instruction memory, a
// single-entry instruction holding register, and redirect handling.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at posedge clk. Once mem_req_valid is high, mem_req_addr changes only
// after a redirect in a cycle without an accept. inst/inst_pc hold while
// inst_valid is high and nothing consumes them.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [1:0]  dbg_state
);

  ifu_state_e  state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        drop;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = word_align(redirect_pc);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_REQ;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_REQ: begin
        if (mem_req_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (drop || redirect_valid) state_nxt = ST_REQ;
          else                        state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || inst_ready) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  // Output decode. Reset masks the valids so nothing leaks out while rst is high.
  always_comb begin
    mem_req_valid = 1'b0;
    inst_valid    = 1'b0;
    if (!rst) begin
      mem_req_valid = (state == ST_REQ);
      inst_valid    = (state == ST_HOLD);
    end
  end

  assign mem_req_addr = fetch_pc;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign dbg_state    = state;

  // Datapath: fetch PC, in-flight PC, drop flag and the instruction holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= 32'd0;
      drop        <= 1'b0;
      inst_q      <= 32'd0;
      inst_pc_q   <= 32'd0;
    end else begin
      unique case (state)
        ST_REQ: begin
          if (mem_req_ready) begin
            inflight_pc <= fetch_pc;
            if (redirect_valid) drop <= 1'b1;
          end
          if (redirect_valid) fetch_pc <= redirect_tgt;
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            if (!drop && !redirect_valid) begin
              inst_q    <= mem_resp_data;
              inst_pc_q <= inflight_pc;
              fetch_pc  <= inflight_pc + INST_BYTES;
            end else begin
              drop <= 1'b0;
              if (redirect_valid) fetch_pc <= redirect_tgt;
            end
          end else if (redirect_valid) begin
            // Response for the old path is still owed; remember to discard it.
            drop     <= 1'b1;
            fetch_pc <= redirect_tgt;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) fetch_pc <= redirect_tgt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a per-cycle vector table plus hand-written
// sequences for memory stalls, core back-pressure and mid-flight reset.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rpc;
    logic        ir;
    logic        mrr;
    logic        mrv;
    logic [31:0] mrd;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  // Memory contents as seen by the bench: a fixed scramble of the address.
  function automatic logic [31:0] md(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic r, input logic rdv, input logic [31:0] rpc,
                              input logic ir, input logic mrr, input logic mrv,
                              input logic [31:0] mrd, input logic e_rv,
                              input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rst = r; v.rdv = rdv; v.rpc = rpc; v.ir = ir; v.mrr = mrr; v.mrv = mrv;
    v.mrd = mrd; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = md(e_pc); v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 time unit later
  task automatic drive(input logic r, input logic rdv, input logic [31:0] rpc,
                       input logic ir, input logic mrr, input logic mrv,
                       input logic [31:0] mrd);
    @(negedge clk);
    rst = r; redirect_valid = rdv; redirect_pc = rpc; inst_ready = ir;
    mem_req_ready = mrr; mem_resp_valid = mrv; mem_resp_data = mrd;
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    drive(v.rst, v.rdv, v.rpc, v.ir, v.mrr, v.mrv, v.mrd);
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".mem_req_valid"}, {31'd0, mem_req_valid}, {31'd0, v.e_rv});
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, v.e_iv});
    if (v.e_rv) chk({tag, ".mem_req_addr"}, mem_req_addr, v.e_addr);
    if (v.e_iv) begin
      chk({tag, ".inst"}, inst, v.e_inst);
      chk({tag, ".inst_pc"}, inst_pc, v.e_pc);
    end
  endtask

  localparam logic [31:0] B = 32'h8000_0000;

  initial begin
    logic [31:0] held_inst;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'd0;

    // reset values
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst.mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst.inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.inst", inst, 32'd0);
    chk("rst.inst_pc", inst_pc, 32'd0);
    chk("rst.state", {30'd0, dbg_state}, 32'd0);

    // zero-wait memory: three sequential fetches, one every 3 cycles
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,            1, B + 4*k, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(B + 4*k),  0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,            0, 0, 1, B + 4*k));
    end
    // reset, fetch 0x80000000, then redirect in the accept cycle of 0x80000004
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, B, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(B),             0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,                 0, 0, 1, B));
    vecs.push_back(mk(0, 1, B+32'h100, 0, 1, 0, 0,         1, B+4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(B+4),           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, B+32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(B+32'h100),     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,                 0, 0, 1, B+32'h100));
    // redirect to unaligned 0x80000203 during WAIT; stale response dropped
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, B+32'h104, 0, 0));
    vecs.push_back(mk(0, 1, B+32'h203, 0, 0, 0, 0,         0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(B+32'h104),     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, B+32'h200, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(B+32'h200),     0, 0, 0, 0));
    // redirect together with inst_ready in HOLD: redirect target wins
    vecs.push_back(mk(0, 1, B+32'h300, 1, 0, 0, 0,         0, 0, 1, B+32'h200));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, B+32'h300, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(B+32'h300),     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,                 0, 0, 1, B+32'h300));
    // redirect in REQ without accept, then PC wrap past 0xFFFFFFFC
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0,     1, B+32'h304, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(32'hFFFF_FFFC), 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,                 0, 0, 1, 32'hFFFF_FFFC));
    // redirect coinciding with a live response: response discarded
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, 32'd0, 0, 0));
    vecs.push_back(mk(0, 1, B+32'h40, 0, 0, 1, md(32'd0),  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,                 1, B+32'h40, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, md(B+32'h40),      0, 0, 0, 0));
    // stray response in HOLD is ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF,     0, 0, 1, B+32'h40));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,                 0, 0, 1, B+32'h40));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 1, B+32'h44, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // memory stall: ready low 4 cycles, then response latency 3
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("stall.req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("stall.req_addr", mem_req_addr, B);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("stall.accept_addr", mem_req_addr, B);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("stall.no_dup_req", {31'd0, mem_req_valid}, 32'd0);
      chk("stall.no_inst", {31'd0, inst_valid}, 32'd0);
    end
    drive(0, 0, 0, 0, 1, 1, md(B));
    chk("stall.resp_no_req", {31'd0, mem_req_valid}, 32'd0);

    // core back-pressure: inst_ready low 5 cycles in HOLD
    held_inst = md(B);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("hold.inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold.inst", inst, held_inst);
      chk("hold.inst_pc", inst_pc, B);
      chk("hold.no_req", {31'd0, mem_req_valid}, 32'd0);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("hold.consume_valid", {31'd0, inst_valid}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("hold.next_addr", mem_req_addr, B + 4);
    chk("hold.next_req", {31'd0, mem_req_valid}, 32'd1);

    // reset while in WAIT
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wait.state", {30'd0, dbg_state}, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst2.req_valid", {31'd0, mem_req_valid}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst2.state", {30'd0, dbg_state}, 32'd0);
    chk("rst2.req_valid_after", {31'd0, mem_req_valid}, 32'd1);
    chk("rst2.req_addr", mem_req_addr, B);
    chk("rst2.inst", inst, 32'd0);
    chk("rst2.inst_pc", inst_pc, 32'd0);
    chk("rst2.inst_valid", {31'd0, inst_valid}, 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
